sig_mult_iter: RTL and testbench

SIG_MULT_ITER -- requirements
Module: sig_mult_iter

---
 rtl/sig_mult_pkg.sv | 26 ++
 rtl/sig_mult_iter_booth_pp_row.sv | 34 +++
 rtl/sig_mult_iter.sv | 140 ++++++++++++++
 tb/tb_sig_mult_iter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_mult_pkg.sv
// Shared significand-multiplier definitions: width constants, size derivations
// and the iterative multiplier state encoding.
package sig_mult_pkg;

    localparam int SIG_WIDTH_DP = 52;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic int prod_w(input int sig_width);
        return 2 * (sig_width + 1);
    endfunction

    // Radix-4 digits over the operand zero-extended by one MSB.
    function automatic int npp(input int sig_width);
        return (sig_width + 3) / 2;
    endfunction

    function automatic int ncyc(input int sig_width, input int pp_per_cycle);
        return (npp(sig_width) + pp_per_cycle - 1) / pp_per_cycle;
    endfunction

endpackage

// File: rtl/sig_mult_iter_booth_pp_row.sv
// One radix-4 Booth partial-product row, sign-extended to the full product
// width; neg flips the sign of every selected multiple.
module booth_pp_row
    import sig_mult_pkg::*;
#(
    parameter int SIG_WIDTH = SIG_WIDTH_DP,
    localparam int PROD_W   = prod_w(SIG_WIDTH)
) (
    input  logic [2:0]           digit,
    input  logic [SIG_WIDTH:0]   b,
    input  logic                 neg,
    output logic [PROD_W-1:0]    row
);

    logic               sel_one;
    logic               sel_two;
    logic               flip;
    logic [PROD_W-1:0]  mag;

    always_comb begin
        sel_one = digit[1] ^ digit[0];
        sel_two = (digit[2] & ~digit[1] & ~digit[0]) | (~digit[2] & digit[1] & digit[0]);
        flip    = digit[2] ^ neg;
        mag     = '0;
        if (sel_one) begin
            mag = PROD_W'(b);
        end else if (sel_two) begin
            mag = PROD_W'({b, 1'b0});
        end
        // Two's complement of zero is zero, so -0 digits need no special case.
        row = flip ? (~mag + PROD_W'(1)) : mag;
    end

endmodule

// File: rtl/sig_mult_iter.sv
// Iterative radix-4 Booth significand multiplier producing a carry-save product,
// PP_PER_CYCLE partial products compressed per BUSY cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | compressing PP_PER_CYCLE Booth rows per cycle for NCYC cycles
// DONE  | carry-save product held on sum/carry until out_ready
module sig_mult_iter
    import sig_mult_pkg::*;
#(
    parameter int SIG_WIDTH    = SIG_WIDTH_DP,
    parameter int PP_PER_CYCLE = 3,
    localparam int PROD_W      = prod_w(SIG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIG_WIDTH:0]   a_in,
    input  logic [SIG_WIDTH:0]   b_in,
    input  logic                 neg_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PROD_W-1:0]    sum,
    output logic [PROD_W-1:0]    carry
);

    localparam int NCYC  = ncyc(SIG_WIDTH, PP_PER_CYCLE);
    localparam int CNT_W = $clog2(NCYC + 1);
    localparam int AW    = 2 * NCYC * PP_PER_CYCLE + 1;
    localparam int SH_W  = $clog2(2 * NCYC * PP_PER_CYCLE + 1);

    mult_state_t         state;
    mult_state_t         state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [SH_W-1:0]     off;
    logic [AW-1:0]       a_sh;
    logic [SIG_WIDTH:0]  b_q;
    logic                neg_q;
    logic [PROD_W-1:0]   acc_s;
    logic [PROD_W-1:0]   acc_c;
    logic [PROD_W-1:0]   csa_s;
    logic [PROD_W-1:0]   csa_c;
    logic [PROD_W-1:0]   rows_sh [PP_PER_CYCLE];
    logic                accept;
    logic                step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = BUSY;
                BUSY:    if (cnt == CNT_W'(NCYC - 1)) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_ready && in_valid && !flush;
        step      = (state == BUSY) && !flush;
        sum       = out_valid ? acc_s : '0;
        carry     = out_valid ? acc_c : '0;
    end

    // a_sh walks right by one digit group per cycle, so row j always reads the
    // same window; the padding above a_in makes out-of-range digits zero.
    for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_row
        logic [PROD_W-1:0] row;

        booth_pp_row #(.SIG_WIDTH(SIG_WIDTH)) u_row (
            .digit (a_sh[2*j +: 3]),
            .b     (b_q),
            .neg   (neg_q),
            .row   (row)
        );

        assign rows_sh[j] = row << (off + SH_W'(2 * j));
    end

    always_comb begin
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        logic [PROD_W-1:0] t;
        logic [PROD_W-1:0] s_n;
        s   = acc_s;
        c   = acc_c;
        t   = '0;
        s_n = '0;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            t   = rows_sh[j];
            s_n = s ^ c ^ t;
            c   = ((s & c) | (s & t) | (c & t)) << 1;
            s   = s_n;
        end
        csa_s = s;
        csa_c = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            off   <= '0;
            a_sh  <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            acc_s <= '0;
            acc_c <= '0;
        end else if (accept) begin
            cnt   <= '0;
            off   <= '0;
            a_sh  <= AW'({a_in, 1'b0});
            b_q   <= b_in;
            neg_q <= neg_in;
            acc_s <= '0;
            acc_c <= '0;
        end else if (step) begin
            cnt   <= cnt + CNT_W'(1);
            off   <= off + SH_W'(2 * PP_PER_CYCLE);
            a_sh  <= a_sh >> (2 * PP_PER_CYCLE);
            acc_s <= csa_s;
            acc_c <= csa_c;
        end
    end

endmodule

// File: tb/tb_sig_mult_iter.sv
// Bench for sig_mult_iter: default instance plus three alternate width/rate
// configurations, checked against plain integer multiplication.
module tb_sig_mult_iter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [52:0]   a_w;
    logic [52:0]   b_w;
    logic          neg;
    logic          flush;
    logic          out_ready;
    logic          iv  [4];
    logic          ir  [4];
    logic          ov  [4];
    logic [127:0]  sum_a   [4];
    logic [127:0]  carry_a [4];

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    function automatic int sw_of(input int i);
        return (i == 1) ? 10 : (i == 2) ? 23 : 52;
    endfunction

    function automatic int ppc_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : (i == 2) ? 4 : 27;
    endfunction

    function automatic int ncyc_of(input int i);
        int digits;
        digits = (sw_of(i) + 3) / 2;
        return (digits + ppc_of(i) - 1) / ppc_of(i);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int SWG = (g == 1) ? 10 : (g == 2) ? 23 : 52;
        localparam int PPG = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 27;
        localparam int PWG = 2 * (SWG + 1);
        logic [PWG-1:0] s_l;
        logic [PWG-1:0] c_l;

        sig_mult_iter #(.SIG_WIDTH(SWG), .PP_PER_CYCLE(PPG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a_in      (a_w[SWG:0]),
            .b_in      (b_w[SWG:0]),
            .neg_in    (neg),
            .flush     (flush),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .sum       (s_l),
            .carry     (c_l)
        );

        assign sum_a[g]   = 128'(s_l);
        assign carry_a[g] = 128'(c_l);
    end

    function automatic logic [127:0] model(input int idx, input logic [52:0] a,
                                           input logic [52:0] b, input logic n);
        logic [127:0] prod;
        logic [127:0] mask;
        prod = 128'(a) * 128'(b);
        mask = (128'(1) << (2 * (sw_of(idx) + 1))) - 128'(1);
        return (n ? (128'(0) - prod) : prod) & mask;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic launch(input int idx, input logic [52:0] a, input logic [52:0] b, input logic n);
        a_w     = a;
        b_w     = b;
        neg     = n;
        iv[idx] = 1'b1;
        @(negedge clk);
        iv[idx] = 1'b0;
    endtask

    // lat counts rising edges from the accepting edge (inclusive) to the one raising out_valid.
    task automatic collect(input int idx, output logic [127:0] res, output int lat);
        logic [127:0] mask;
        lat = 1;
        while (!ov[idx] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        mask = (128'(1) << (2 * (sw_of(idx) + 1))) - 128'(1);
        res  = (sum_a[idx] + carry_a[idx]) & mask;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input int idx, input logic [52:0] a,
                             input logic [52:0] b, input logic n, input logic [127:0] exp);
        logic [127:0] res;
        int           lat;
        launch(idx, a, b, n);
        collect(idx, res, lat);
        check({name, "_val"}, res, exp);
        check({name, "_lat"}, 128'(lat), 128'(ncyc_of(idx) + 1));
        pop();
    endtask

    typedef struct {
        logic [52:0]  a;
        logic [52:0]  b;
        logic         n;
        logic [127:0] exp;
    } vec_t;

    localparam logic [52:0] ONES = 53'h1F_FFFF_FFFF_FFFF;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [8];
        logic [127:0] res;
        logic [127:0] s0;
        logic [127:0] c0;
        logic [52:0]  ra;
        logic [52:0]  rb;
        logic         rn;
        logic [52:0]  amask;
        int           lat;

        tbl[0] = '{a: ONES,      b: ONES,           n: 1'b0,
                   exp: (128'(1) << 106) - (128'(1) << 54) + 128'(1)};
        tbl[1] = '{a: 53'(1) << 52, b: 53'(1) << 52, n: 1'b1,
                   exp: (128'(1) << 106) - (128'(1) << 104)};
        tbl[2] = '{a: 53'd0,     b: 53'h1234_5678_9ABC, n: 1'b1, exp: 128'd0};
        tbl[3] = '{a: 53'd0,     b: ONES,           n: 1'b0, exp: 128'd0};
        tbl[4] = '{a: 53'd1,     b: 53'd1,          n: 1'b1, exp: (128'(1) << 106) - 128'(1)};
        tbl[5] = '{a: 53'd3,     b: 53'd5,          n: 1'b0, exp: 128'd15};
        tbl[6] = '{a: ONES,      b: 53'd1,          n: 1'b1,
                   exp: (128'(1) << 106) - (128'(1) << 53) + 128'(1)};
        tbl[7] = '{a: 53'(1) << 52, b: 53'd3,       n: 1'b0, exp: 128'(3) << 52};

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) iv[i] = 1'b0;
        a_w = '0; b_w = '0; neg = 1'b0; flush = 1'b0; out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  128'(ir[0]), 128'd1);
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_sum",       sum_a[0],    128'd0);
        check("rst_carry",     carry_a[0],  128'd0);

        // Request already pending when reset releases: taken on the first edge.
        rst_n = 1'b1;
        launch(0, 53'd3, 53'd7, 1'b0);
        check("first_edge_accept", 128'(ir[0]), 128'd0);
        collect(0, res, lat);
        check("first_edge_val", res, 128'd21);
        check("first_edge_lat", 128'(lat), 128'(ncyc_of(0) + 1));
        pop();

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("tbl%0d", i), 0, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].exp);
        end

        // Backpressure: result held unchanged while out_ready stays low.
        launch(0, 53'h0A5A_5A5A_5A5A5, 53'h1_2345_6789_ABCD, 1'b1);
        collect(0, res, lat);
        check("hold_val", res, model(0, 53'h0A5A_5A5A_5A5A5, 53'h1_2345_6789_ABCD, 1'b1));
        s0 = sum_a[0];
        c0 = carry_a[0];
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), 128'(ov[0]), 128'd1);
            check($sformatf("hold%0d_ready", i), 128'(ir[0]), 128'd0);
            check($sformatf("hold%0d_sum", i),   sum_a[0],    s0);
            check($sformatf("hold%0d_carry", i), carry_a[0],  c0);
            @(negedge clk);
        end
        pop();
        check("after_pop_valid", 128'(ov[0]), 128'd0);
        check("after_pop_ready", 128'(ir[0]), 128'd1);

        // Flush in BUSY cycle 4 alongside a fresh request.
        launch(0, ONES, ONES, 1'b0);
        check("busy_sum_hidden",   sum_a[0],   128'd0);
        check("busy_carry_hidden", carry_a[0], 128'd0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        a_w = 53'd9; b_w = 53'd9; iv[0] = 1'b1;
        @(negedge clk);
        flush = 1'b0; iv[0] = 1'b0;
        check("flush_busy_idle",  128'(ir[0]), 128'd1);
        check("flush_busy_valid", 128'(ov[0]), 128'd0);
        run_check("after_flush", 0, 53'd1234567, 53'd7654321, 1'b1,
                  model(0, 53'd1234567, 53'd7654321, 1'b1));

        // Flush beats in_valid while idle.
        flush = 1'b1; iv[0] = 1'b1;
        @(negedge clk);
        flush = 1'b0; iv[0] = 1'b0;
        check("flush_idle_no_accept", 128'(ir[0]), 128'd1);

        // Flush in DONE drops the result.
        launch(0, 53'd11, 53'd13, 1'b0);
        collect(0, res, lat);
        check("pre_flush_done_val", res, 128'd143);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_valid", 128'(ov[0]), 128'd0);
        check("flush_done_sum",   sum_a[0],    128'd0);

        // Asynchronous reset in BUSY cycle 6.
        launch(0, ONES, 53'd5, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 128'(ir[0]), 128'd1);
        check("async_rst_valid", 128'(ov[0]), 128'd0);
        check("async_rst_sum",   sum_a[0],    128'd0);
        check("async_rst_carry", carry_a[0],  128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_rst", 0, ONES, ONES, 1'b1, model(0, ONES, ONES, 1'b1));

        // Random operands on every configuration.
        for (int idx = 0; idx < 4; idx++) begin
            amask = 53'((64'(1) << (sw_of(idx) + 1)) - 64'(1));
            for (int i = 0; i < ((idx == 0) ? 300 : 2000); i++) begin
                ra = 53'({$urandom(), $urandom()}) & amask;
                rb = 53'({$urandom(), $urandom()}) & amask;
                rn = 1'($urandom_range(0, 1));
                if (i % 64 == 0) ra = amask;
                if (i % 64 == 1) rb = amask;
                launch(idx, ra, rb, rn);
                collect(idx, res, lat);
                n_cmp++;
                if (res !== model(idx, ra, rb, rn) || lat != ncyc_of(idx) + 1) begin
                    n_bad++;
                    $display("FAIL rand_cfg%0d: a=%h b=%h neg=%0d got %h lat %0d, expected %h lat %0d",
                             idx, ra, rb, rn, res, lat, model(idx, ra, rb, rn), ncyc_of(idx) + 1);
                end
                pop();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
